bus_rr_arbiter: RTL and testbench
=================================

// Module: bus_rr_arbiter
// PURPOSE
//  Round-robin arbiter that merges N_REQ requester streams (d/vld) onto one shared
//  output bus with a registered output stage and per-requester ready backpressure.
//  Sits between the test_gen-style stream producers and a single downstream consumer.
//  Each stream carries a 16-bit payload with a valid flag.
//  Bursts are capped so that no requester can starve the others.
// PARAMETERS
//  N_REQ      4   number of requesters (>=2)
//  DW         16  payload width
//  MAX_BURST  4   max consecutive beats per grant before forced rotation (>=1)
//  IDW        $clog2(N_REQ)  localparam, source-id width
// PORTS
//  clk        in   1         clock, all logic on posedge
//  rst        in   1         reset, asynchronous, active-high
//  in_d       in   DW x N_REQ  requester payloads (unpacked [N_REQ])
//  in_vld     in   N_REQ     requester valid
//  in_rdy     out  N_REQ     per-requester ready; at most one bit high
//  out_d      out  DW        registered output payload
//  out_vld    out  1         registered output valid
//  out_src    out  IDW       index of requester that produced out_d
//  out_rdy    in   1         downstream ready
//  stat_sel   in   IDW       stats select (only with BUS_ARB_STATS_EN)
//  stat_cnt   out  16        beat count of requester stat_sel (only with BUS_ARB_STATS_EN)
// BEHAVIOUR
//  - Transfer rule, both sides: a beat moves when vld && rdy at posedge.
//    A producer holds d/vld stable while vld && !rdy.
//  - Reset (async): out_vld=0, out_d=0, out_src=0, in_rdy=0, state=IDLE, ptr=0,
//    burst_cnt=0, stats=0. Reset mid-burst discards the beat held in the output register.
//  - FSM IDLE: scan in_vld from ptr upward, wrapping N_REQ-1 -> 0, and take the first set bit.
//    If one is found: register grant g, burst_cnt=0, go to GRANT. Otherwise stay in IDLE.
//  - FSM GRANT(g): in_rdy[g] = !out_vld || out_rdy. All other in_rdy bits are 0.
//    in_rdy is a function of registered state and out_rdy only, so there is no comb
//    path from in_vld.
//    * on transfer: out_d<=in_d[g], out_src<=g, out_vld<=1, burst_cnt++.
//    * release -> IDLE, ptr<=(g+1) mod N_REQ, when either:
//      (a) in_vld[g]==0 while in_rdy[g]==1, or
//      (b) a transfer makes burst_cnt reach MAX_BURST.
//    * stalled cycles (in_rdy[g]==0) neither count nor release.
//  - Output register: out_vld clears when out_rdy==1 and no new transfer happens that cycle.
//    Back-to-back beats run at full rate within a grant.
//    While out_vld && !out_rdy, out_d and out_src stay stable.
//  - Latency: in_vld rises at cycle t in IDLE -> in_rdy at t+1 -> out_vld at t+2.
//    Every rotation costs one IDLE bubble cycle.
//  - Fairness: a sole active requester is re-granted after each bubble.
//    MAX_BURST=1 gives per-beat rotation.
//  - Simultaneous release and reset: reset wins.
// CONFIGURATION
//  BUS_ARB_STATS_EN defined:
//    - per-requester 16-bit beat counters, incremented on each accepted input beat.
//    - counters saturate at 0xFFFF and are cleared by rst.
//    - stat_cnt = counter[stat_sel], combinational read.
//  BUS_ARB_STATS_EN undefined: stat_sel/stat_cnt ports and counters are absent.
//    Datapath behaviour is identical to the defined case.
// TESTING
//  1. rst, req0 sends 0x0001..0x0003 back-to-back, out_rdy=1
//     -> out_vld from cycle t+2, out_src=0, out_d 1,2,3 in order.
//  2. all 4 in_vld held high, MAX_BURST=4, out_rdy=1
//     -> out_src 0,0,0,0,1,1,1,1,2,... with one-cycle bubble between bursts.
//  3. out_rdy=0 for 5 cycles while out_vld=1
//     -> out_d/out_src stable, in_rdy all 0, no beat lost or duplicated after resume.
//  4. grant on req3 ends, req0 and req2 valid -> next grant is req0 (ptr wrap).
//  5. rst asserted mid-burst -> out_vld=0 and in_rdy=0 immediately.
//     After release, first grant goes to the lowest valid index from ptr=0.
//  6. BUS_ARB_STATS_EN: 70000 beats from req1
//     -> stat_sel=1 gives 0xFFFF, stat_sel=2 gives 0x0000.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bus_rr_arbiter
//   Round-robin arbiter that merges N_REQ valid/ready requester streams onto one
//   registered output bus. A grant lasts until the holder drops valid or has
//   moved MAX_BURST beats. After that the arbiter spends one IDLE cycle and
//   rescans, starting from the requester after the previous holder.
//
//   Optional feature macro: BUS_ARB_STATS_EN
//     When defined, the block adds per-requester saturating 16-bit beat counters
//     and the stat_sel / stat_cnt read port. When undefined, these ports and
//     counters are absent. The datapath behaves the same in both builds.
//
// Ports
//   clk       clock, all logic on posedge
//   rst       asynchronous active-high reset
//   in_d      requester payloads, unpacked [N_REQ]
//   in_vld    requester valid, one bit per requester
//   in_rdy    requester ready; at most one bit high (the current grant)
//   out_d     registered output payload
//   out_vld   registered output valid
//   out_src   index of the requester that produced out_d
//   out_rdy   downstream ready
//   stat_sel  counter select            (BUS_ARB_STATS_EN only)
//   stat_cnt  beat count of stat_sel    (BUS_ARB_STATS_EN only)
// -----------------------------------------------------------------------------

`ifdef BUS_ARB_STATS_EN
// Per-requester beat counter. It saturates at 0xFFFF rather than wrapping, so a
// long-running stream reads as "at least 65535" instead of a small number.
module bus_rr_arbiter_stat_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt <= '0;
    else if (inc && cnt != 16'hFFFF)  cnt <= cnt + 16'd1;
  end
endmodule
`endif

module bus_rr_arbiter #(
  parameter  int N_REQ     = 4,
  parameter  int DW        = 16,
  parameter  int MAX_BURST = 4,
  localparam int IDW       = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    in_d [N_REQ],
  input  logic [N_REQ-1:0] in_vld,
  output logic [N_REQ-1:0] in_rdy,
  output logic [DW-1:0]    out_d,
  output logic             out_vld,
  output logic [IDW-1:0]   out_src,
  input  logic             out_rdy
`ifdef BUS_ARB_STATS_EN
  ,
  input  logic [IDW-1:0]   stat_sel,
  output logic [15:0]      stat_cnt
`endif
);

  localparam int BCW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [BCW-1:0]   burst_q, burst_d;

  logic             found;
  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   scan_idx;
  int               scan_pos;

  logic             gnt_rdy;
  logic             vld_g;
  logic             xfer;
  logic             last_beat;
  logic [IDW-1:0]   next_ptr;

  // ---------------------------------------------------------------------------
  // Rotating priority scan. It starts at ptr_q and wraps N_REQ-1 -> 0. The
  // offset arithmetic uses int, so a non-power-of-two N_REQ wraps correctly.
  // ---------------------------------------------------------------------------
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;
    scan_pos = 0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_pos = int'(ptr_q) + i;
      if (scan_pos >= N_REQ) scan_pos = scan_pos - N_REQ;
      scan_idx = scan_pos[IDW-1:0];
      if (!found && in_vld[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Grant-side handshake. Ready depends only on registered state and out_rdy.
  // This keeps any combinational path from in_vld to in_rdy out of the design.
  // The output register can take a beat when it is empty or is being drained
  // in the same cycle.
  // ---------------------------------------------------------------------------
  assign gnt_rdy   = (state_q == GRANT) && (!out_vld || out_rdy);
  assign vld_g     = in_vld[grant_q];
  assign xfer      = gnt_rdy && vld_g;
  assign last_beat = xfer && (burst_q == BCW'(MAX_BURST - 1));
  assign next_ptr  = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + IDW'(1);

  always_comb begin
    in_rdy = '0;
    if (gnt_rdy) in_rdy[grant_q] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) burst_d = burst_q + BCW'(1);
        // Release when the holder is offered a slot and has nothing to send,
        // or when this beat fills the burst budget. A stalled cycle
        // (gnt_rdy == 0) does neither.
        if ((gnt_rdy && !vld_g) || last_beat) begin
          state_d = IDLE;
          ptr_d   = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register. A new beat overwrites the register in the same cycle the
  // old one drains, so a grant streams at full rate. If nothing is loaded,
  // out_rdy only empties the register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_d   <= '0;
      out_src <= '0;
    end else if (xfer) begin
      out_vld <= 1'b1;
      out_d   <= in_d[grant_q];
      out_src <= grant_q;
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end

`ifdef BUS_ARB_STATS_EN
  logic [15:0] stat_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_stat
    bus_rr_arbiter_stat_ctr u_ctr (
      .clk (clk),
      .rst (rst),
      .inc (xfer && (grant_q == IDW'(i))),
      .cnt (stat_arr[i])
    );
  end

  // When N_REQ is not a power of two, a select value past the last requester
  // reads as zero.
  assign stat_cnt = (int'(stat_sel) < N_REQ) ? stat_arr[stat_sel] : '0;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter. The reference model predicts the output beat order
// from the arbitration rules:
//   - the next grant is the first non-empty requester at or after the pointer;
//   - that requester moves min(MAX_BURST, remaining) beats;
//   - the pointer then moves to the requester after it.
// The model also checks the handshake invariants every cycle.
module tb_bus_rr_arbiter;
  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int IDW = 2;
`ifdef BUS_ARB_STATS_EN
  localparam int MB  = 16;
`else
  localparam int MB  = 4;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  in_d [N];
  logic [N-1:0]   in_vld;
  logic [N-1:0]   in_rdy;
  logic [DW-1:0]  out_d;
  logic           out_vld;
  logic [IDW-1:0] out_src;
  logic           out_rdy;
`ifdef BUS_ARB_STATS_EN
  logic [IDW-1:0] stat_sel;
  logic [15:0]    stat_cnt;
`endif

  always #5 clk = ~clk;

  bus_rr_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MB)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_d    (in_d),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .out_d   (out_d),
    .out_vld (out_vld),
    .out_src (out_src),
    .out_rdy (out_rdy)
`ifdef BUS_ARB_STATS_EN
    ,
    .stat_sel(stat_sel),
    .stat_cnt(stat_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Producer model: requester i has len[i] beats in pay[i]; head[i] is the next one.
  logic [DW-1:0] pay [N][16];
  int            len [N];
  int            head[N];
  int            exp_q[$];   // expected output beats, encoded as (src << 16) | data

  function automatic bit pending();
    bit p = 0;
    for (int i = 0; i < N; i++) if (head[i] < len[i]) p = 1;
    return p;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (head[i] < len[i]) begin
        in_vld[i] = 1'b1;
        in_d[i]   = pay[i][head[i]];
      end else begin
        in_vld[i] = 1'b0;
        in_d[i]   = '0;
      end
    end
  endtask

  task automatic fill(input int i, input int n);
    len[i] = n;
    for (int j = 0; j < n; j++) pay[i][j] = DW'($urandom);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    in_vld  = '0;
    out_rdy = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_d[i] = '0;
      len[i]  = 0;
      head[i] = 0;
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Round-robin reference. Every queued stream is valid from the first cycle
  // and stays valid until it empties, so the beat order does not depend on the
  // stall pattern.
  task automatic build_expected();
    int rem[N];
    int h[N];
    int p;
    int g;
    int n;
    int c;
    p = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = len[i] - head[i];
      h[i]   = head[i];
    end
    while (1) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        c = (p + k) % N;
        if (g < 0 && rem[c] > 0) g = c;
      end
      if (g < 0) break;
      n = (rem[g] < MB) ? rem[g] : MB;
      for (int j = 0; j < n; j++) exp_q.push_back((g << 16) | int'(pay[g][h[g] + j]));
      h[g]   += n;
      rem[g] -= n;
      p = (g + 1) % N;
    end
  endtask

  // Runs queued traffic to completion. It scoreboards the output beats and
  // checks these every cycle: the one-hot ready, no ready while the output is
  // stalled, and output stability under stall.
  //   stall_at   : after this many output beats, hold out_rdy low for 5 cycles
  //   bubble_chk : check the spacing of output beats at full rate
  //   wrap_inj   : once req3 is granted, expose the queued beats of req0/req2
  task automatic run_traffic(input int rdy_pct, input int stall_at,
                             input bit bubble_chk, input bit wrap_inj);
    int cyc, beats_out, stall_left, last_cyc, last_src, run_len, got, expv, eg;
    bit stall_done, hold, inj_done;
    logic [DW-1:0]  hd;
    logic [IDW-1:0] hs;
    logic [N-1:0]   acc;
    cyc = 0; beats_out = 0; stall_left = 0; last_cyc = -1; last_src = -1; run_len = 0;
    stall_done = 0; hold = 0; inj_done = 0; hd = '0; hs = '0;
    drive_inputs();
    out_rdy = ($urandom_range(99) < rdy_pct);
    while ((pending() || exp_q.size() != 0 || out_vld) && cyc < 3000) begin
      @(negedge clk);
      n_tests++;
      if ($countones(in_rdy) > 1) begin
        n_fail++; $display("FAIL rdy_onehot: in_rdy=%b, need at most one bit", in_rdy);
      end
      if (out_vld && !out_rdy) begin
        n_tests++;
        if (in_rdy !== '0) begin
          n_fail++; $display("FAIL rdy_in_stall: in_rdy=%b, need 0000", in_rdy);
        end
      end
      if (hold) begin
        n_tests++;
        if (out_vld !== 1'b1 || out_d !== hd || out_src !== hs) begin
          n_fail++;
          $display("FAIL hold: vld=%b d=%h src=%0d, need vld=1 d=%h src=%0d",
                   out_vld, out_d, out_src, hd, hs);
        end
      end
      acc = in_vld & in_rdy;
      if (out_vld && out_rdy) begin
        got = (int'(out_src) << 16) | int'(out_d);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL extra_beat: got %h, none expected", got);
        end else begin
          expv = exp_q.pop_front();
          if (got !== expv) begin
            n_fail++; $display("FAIL order: got %h, expected %h", got, expv);
          end
        end
        if (bubble_chk && last_src >= 0) begin
          eg = (int'(out_src) == last_src && run_len < MB) ? 1 : 2;
          n_tests++;
          if (cyc - last_cyc != eg) begin
            n_fail++; $display("FAIL gap: beat spacing %0d, need %0d", cyc - last_cyc, eg);
          end
        end
        if (last_src >= 0 && int'(out_src) == last_src && run_len < MB) run_len++;
        else run_len = 1;
        last_src = int'(out_src);
        last_cyc = cyc;
        beats_out++;
        if (beats_out == stall_at && !stall_done) begin
          stall_left = 5; stall_done = 1;
        end
      end
      hold = out_vld && !out_rdy;
      hd = out_d;
      hs = out_src;
      if (wrap_inj && !inj_done && in_rdy[3]) begin
        len[0] = 1; len[2] = 1; inj_done = 1;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acc[i]) head[i]++;
      drive_inputs();
      if (stall_left > 0) begin
        out_rdy = 1'b0; stall_left--;
      end else begin
        out_rdy = ($urandom_range(99) < rdy_pct);
      end
      cyc++;
    end
    n_tests++;
    if (pending() || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d beats still expected after %0d cycles", exp_q.size(), cyc);
    end
  endtask

  task automatic test_reset();
    do_reset();
    out_rdy = 1'b1;
    in_vld  = 4'b1111;
    for (int i = 0; i < N; i++) in_d[i] = 16'hABCD;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (out_vld !== 1'b0 || out_d !== '0 || out_src !== '0 || in_rdy !== '0) begin
      n_fail++;
      $display("FAIL reset_async: vld=%b d=%h src=%0d rdy=%b, need all zero",
               out_vld, out_d, out_src, in_rdy);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (out_vld !== 1'b0 || in_rdy !== '0) begin
      n_fail++; $display("FAIL reset_hold: vld=%b rdy=%b, need 0/0000", out_vld, in_rdy);
    end
    in_vld = '0;
    rst = 1'b0;
  endtask

  // Requester 0 sends 1,2,3. The first beat appears two cycles after valid rises.
  task automatic test_latency();
    do_reset();
    out_rdy = 1'b1;
    @(posedge clk); #1;
    in_vld = 4'b0001; in_d[0] = 16'd1;
    @(negedge clk);
    n_tests++;
    if (in_rdy !== 4'b0000 || out_vld !== 1'b0) begin
      n_fail++; $display("FAIL lat_t0: rdy=%b vld=%b, need 0000/0", in_rdy, out_vld);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (in_rdy !== 4'b0001 || out_vld !== 1'b0) begin
      n_fail++; $display("FAIL lat_t1: rdy=%b vld=%b, need 0001/0", in_rdy, out_vld);
    end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k < 3) in_d[0] = DW'(k + 1);
      else       in_vld  = '0;
      @(negedge clk);
      n_tests++;
      if (out_vld !== 1'b1 || out_d !== DW'(k) || out_src !== '0) begin
        n_fail++;
        $display("FAIL lat_beat%0d: vld=%b d=%h src=%0d, need 1/%h/0", k, out_vld, out_d, out_src, k);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (out_vld !== 1'b0) begin
      n_fail++; $display("FAIL lat_end: vld=%b, need 0", out_vld);
    end
  endtask

  task automatic test_all_valid();
    do_reset();
    for (int i = 0; i < N; i++) fill(i, 2 * MB);
    build_expected();
    run_traffic(100, -1, 1'b1, 1'b0);
  endtask

  task automatic test_stall();
    do_reset();
    fill(0, 6);
    fill(1, 6);
    build_expected();
    run_traffic(100, 3, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    do_reset();
    fill(3, 2);
    fill(0, 1); len[0] = 0;
    fill(2, 1); len[2] = 0;
    exp_q.push_back((3 << 16) | int'(pay[3][0]));
    exp_q.push_back((3 << 16) | int'(pay[3][1]));
    exp_q.push_back((0 << 16) | int'(pay[0][0]));
    exp_q.push_back((2 << 16) | int'(pay[2][0]));
    run_traffic(100, -1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_rdy = 1'b1;
    @(posedge clk); #1;
    in_vld = 4'b0011;
    in_d[0] = 16'h1111; in_d[1] = 16'h2222;
    repeat (4) @(negedge clk);
    n_tests++;
    if (out_vld !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: vld=%b, need 1 before reset", out_vld);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (out_vld !== 1'b0 || in_rdy !== '0 || out_d !== '0 || out_src !== '0) begin
      n_fail++;
      $display("FAIL mid_rst: vld=%b rdy=%b d=%h src=%0d, need zeros", out_vld, in_rdy, out_d, out_src);
    end
    in_vld = 4'b0110;
    in_d[2] = 16'h3333;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_rdy !== 4'b0010 || out_vld !== 1'b0) begin
      n_fail++; $display("FAIL mid_regrant: rdy=%b vld=%b, need 0010/0", in_rdy, out_vld);
    end
    @(negedge clk);
    n_tests++;
    if (out_vld !== 1'b1 || out_src !== 2'd1 || out_d !== 16'h2222) begin
      n_fail++; $display("FAIL mid_first: vld=%b src=%0d d=%h, need 1/1/2222", out_vld, out_src, out_d);
    end
    in_vld = '0;
  endtask

  task automatic test_random();
    int pct;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      for (int i = 0; i < N; i++) fill(i, $urandom_range(0, 10));
      pct = (it % 3 == 0) ? 25 : ((it % 3 == 1) ? 60 : 100);
      build_expected();
      run_traffic(pct, -1, 1'b0, 1'b0);
    end
  endtask

`ifdef BUS_ARB_STATS_EN
  task automatic test_stats();
    int beats, cyc, target;
    logic [15:0] want;
    do_reset();
    stat_sel = 2'd1;
    #1;
    n_tests++;
    if (stat_cnt !== 16'h0000) begin
      n_fail++; $display("FAIL stat_rst: cnt=%h, need 0000", stat_cnt);
    end
    out_rdy = 1'b1;
    beats = 0; cyc = 0;
    for (int ph = 0; ph < 2; ph++) begin
      target = (ph == 0) ? 100 : 65540;
      want   = (ph == 0) ? 16'd100 : 16'hFFFF;
      @(posedge clk); #1;
      in_vld = 4'b0010; in_d[1] = 16'h5A5A;
      while (beats < target && cyc < 80000) begin
        @(negedge clk);
        if (in_vld[1] && in_rdy[1]) beats++;
        cyc++;
      end
      @(posedge clk); #1;
      in_vld = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (beats != target || stat_cnt !== want) begin
        n_fail++; $display("FAIL stat_req1: cnt=%h beats=%0d, need %h", stat_cnt, beats, want);
      end
    end
    stat_sel = 2'd2;
    #1;
    n_tests++;
    if (stat_cnt !== 16'h0000) begin
      n_fail++; $display("FAIL stat_req2: cnt=%h, need 0000", stat_cnt);
    end
  endtask
`endif

  initial begin
    rst     = 1'b1;
    in_vld  = '0;
    out_rdy = 1'b0;
    for (int i = 0; i < N; i++) in_d[i] = '0;
`ifdef BUS_ARB_STATS_EN
    stat_sel = '0;
`endif
    test_reset();
    test_latency();
    test_all_valid();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef BUS_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
